sgd_b_dispatch: RTL and testbench
=================================

SGD_B_DISPATCH -- requirements
Module: sgd_b_dispatch

Interface
REQ-001 Parameter NUM_OF_BANKS, default `NUM_OF_BANKS (8), meaning b lanes per output packet.
REQ-002 Parameter LINE_WIDTH, default 512, meaning memory line width, fixed at 16 x 32-bit b values.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; starts a job; sampled only in IDLE.
REQ-006 number_of_samples  input  32  b values per epoch; latched on accepted start.
REQ-007 number_of_epochs  input  16  epochs per job; latched on accepted start.
REQ-008 mem_b_data  input  512  line of 16 b values; lane j is bits [32j+31:32j].
REQ-009 mem_b_valid  input  1  mem_b_data is valid.
REQ-010 mem_b_ready  output  1  a line transfers when valid & ready are both high.
REQ-011 dispatch_axb_b_data  output  32*NUM_OF_BANKS  b packet to the loss block.
REQ-012 dispatch_axb_b_wr_en  output  1  one-cycle write strobe per packet.
REQ-013 dispatch_axb_b_almost_full  input  1  loss-block b FIFO backpressure.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse at job completion.
REQ-016 epoch_cnt  output  16  number of completed epochs in the current job.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, EMIT_LO, EMIT_HI, and DONE.
REQ-018 IDLE: start latches config, clears counters, sets remaining = number_of_samples, and goes to LOAD; if samples==0 or epochs==0 it goes to DONE instead.
REQ-019 LOAD: mem_b_ready=1 only in LOAD; on the handshake the line is captured in a holding register and the FSM goes to EMIT_LO.
REQ-020 EMIT_LO: when almost_full=0, the block writes packet = line lanes 0..7.
REQ-021 After EMIT_LO: if remaining>8, remaining -= 8 and the FSM goes to EMIT_HI; otherwise the epoch ends.
REQ-022 EMIT_HI: when almost_full=0, the block writes packet = line lanes 8..15.
REQ-023 After EMIT_HI: if remaining>8, remaining -= 8 and the FSM goes to LOAD; otherwise the epoch ends.
REQ-024 In the last packet of an epoch, lane i SHALL be zero when i >= remaining; all other lanes pass through unchanged.
REQ-025 At epoch end, the unused lanes of the held line are discarded, because each epoch starts on a fresh line.
REQ-026 At epoch end, epoch_cnt increments and remaining reloads; the FSM goes to LOAD, or to DONE when epoch_cnt+1 == number_of_epochs.
REQ-027 While almost_full=1, the FSM holds in its EMIT state with no write and no state change.
REQ-028 dispatch_axb_b_wr_en and dispatch_axb_b_data SHALL be registered, appearing one cycle after the emit decision.
REQ-029 The block SHALL issue at most one write per cycle, and wr_en is never high in IDLE, LOAD, or DONE.
REQ-030 DONE: done=1 for exactly one cycle, busy=0 from the next cycle, then the FSM goes to IDLE.
REQ-031 start is ignored in every state except IDLE.
REQ-032 Packets per epoch SHALL equal ceil(samples/8); lines per epoch SHALL equal ceil(samples/16).
REQ-033 Back-to-back throughput is 2 packets per 3 cycles, with no bubble when almost_full stays low.

Reset
REQ-034 When rst_n=0 at a clock edge, the FSM goes to IDLE and busy, done, mem_b_ready and wr_en all go to 0.
REQ-035 Reset also clears epoch_cnt, remaining and dispatch_axb_b_data to 0.
REQ-036 Reset mid-job SHALL abandon the job immediately with no further writes and no done pulse; any held line is dropped.

Structure
REQ-037 NUM_OF_BANKS and the FSM state enum (typedef) SHALL live in the shared sgd_defines / sgd package.
REQ-038 The module is flat, with no sub-module, because the holding register, lane mask, and counters are all local.

Verification
REQ-039 samples=16, epochs=1, always valid, almost_full=0 -> exactly 2 writes (lanes 0-7 then 8-15), then one done pulse, epoch_cnt=1.
REQ-040 samples=13, epochs=2 -> 4 writes; the 2nd and 4th packets have lanes 5-7 = 0; 2 lines consumed; epoch_cnt=2 at done.
REQ-041 samples=8, epochs=3 -> 3 writes; each consumes a new line, with lanes 8-15 discarded; 3 lines consumed.
REQ-042 samples=32, almost_full raised for 10 cycles after the 1st write -> no wr_en during the stall, data held, 4 writes total in order.
REQ-043 samples=0, epochs=5 -> no mem_b_ready, no write, done pulse 2 cycles after start.
REQ-044 rst_n low for 1 cycle between the 2nd and 3rd write of a samples=64 job -> no further writes, no done, busy=0, and a new start is accepted afterwards.

Source files
------------

// File: rtl/sgd_b_dispatch_pkg.sv
// Shared definitions for the b-value dispatcher: lane geometry and FSM state type.
package sgd_b_dispatch_pkg;

    localparam int unsigned NUM_OF_BANKS = 8;
    localparam int unsigned LINE_WIDTH   = 512;
    localparam int unsigned B_WIDTH      = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StEmitLo,
        StEmitHi,
        StDone
    } dispatch_state_e;

    // Lane 'lane' of the current packet carries a real sample while it is below 'remaining'.
    function automatic logic lane_live(input int unsigned lane, input logic [31:0] remaining);
        return 32'(lane) < remaining;
    endfunction

endpackage

// File: rtl/sgd_b_dispatch_if.sv
// Memory-line input stream and loss-block packet output of the b dispatcher.
interface sgd_b_dispatch_if
    import sgd_b_dispatch_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = sgd_b_dispatch_pkg::LINE_WIDTH,
    parameter int unsigned NUM_OF_BANKS = sgd_b_dispatch_pkg::NUM_OF_BANKS
);

    logic [LINE_WIDTH-1:0]           mem_b_data;
    logic                            mem_b_valid;
    logic                            mem_b_ready;
    logic [B_WIDTH*NUM_OF_BANKS-1:0] dispatch_axb_b_data;
    logic                            dispatch_axb_b_wr_en;
    logic                            dispatch_axb_b_almost_full;

    // The dispatcher side.
    modport master (
        input  mem_b_data,
        input  mem_b_valid,
        input  dispatch_axb_b_almost_full,
        output mem_b_ready,
        output dispatch_axb_b_data,
        output dispatch_axb_b_wr_en
    );

    // Memory reader and loss block side.
    modport slave (
        output mem_b_data,
        output mem_b_valid,
        output dispatch_axb_b_almost_full,
        input  mem_b_ready,
        input  dispatch_axb_b_data,
        input  dispatch_axb_b_wr_en
    );

endinterface

// File: rtl/sgd_b_dispatch.sv
// Splits 16-lane memory lines of b values into two 8-lane packets per line, repeated per epoch,
// zeroing lanes past the end of the sample set in the last packet of each epoch.
module sgd_b_dispatch
    import sgd_b_dispatch_pkg::*;
#(
    parameter int unsigned NUM_OF_BANKS = sgd_b_dispatch_pkg::NUM_OF_BANKS,
    parameter int unsigned LINE_WIDTH   = sgd_b_dispatch_pkg::LINE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      number_of_samples,
    input  logic [15:0]      number_of_epochs,
    sgd_b_dispatch_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [15:0]      epoch_cnt
);

    localparam int unsigned PKT_WIDTH = B_WIDTH * NUM_OF_BANKS;
    localparam logic [31:0] BANKS     = 32'(NUM_OF_BANKS);

    dispatch_state_e       state_q, state_d;
    logic [31:0]           samples_q, samples_d;
    logic [15:0]           epochs_q, epochs_d;
    logic [15:0]           epoch_cnt_q, epoch_cnt_d;
    logic [31:0]           remaining_q, remaining_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [PKT_WIDTH-1:0]  data_q;
    logic                  wr_en_q;

    logic                  emit;
    logic                  mem_ready;
    logic [15:0]           epoch_inc;
    logic [PKT_WIDTH-1:0]  half;
    logic [PKT_WIDTH-1:0]  packet;

    assign epoch_inc = epoch_cnt_q + 16'd1;

    // Next-state logic and counter updates.
    always_comb begin
        state_d     = state_q;
        samples_d   = samples_q;
        epochs_d    = epochs_q;
        epoch_cnt_d = epoch_cnt_q;
        remaining_d = remaining_q;
        line_d      = line_q;
        emit        = 1'b0;
        mem_ready   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    samples_d   = number_of_samples;
                    epochs_d    = number_of_epochs;
                    epoch_cnt_d = '0;
                    remaining_d = number_of_samples;
                    if (number_of_samples == '0 || number_of_epochs == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end

            StLoad: begin
                mem_ready = 1'b1;
                if (bus.mem_b_valid) begin
                    line_d  = bus.mem_b_data;
                    state_d = StEmitLo;
                end
            end

            StEmitLo, StEmitHi: begin
                if (!bus.dispatch_axb_b_almost_full) begin
                    emit = 1'b1;
                    if (remaining_q > BANKS) begin
                        remaining_d = remaining_q - BANKS;
                        state_d     = (state_q == StEmitLo) ? StEmitHi : StLoad;
                    end else begin
                        // Epoch ends here; whatever is left of the held line is dropped.
                        epoch_cnt_d = epoch_inc;
                        remaining_d = samples_q;
                        state_d     = (epoch_inc == epochs_q) ? StDone : StLoad;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Packet assembly: pick the line half, then blank lanes beyond the remaining samples.
    // The mask is a no-op for non-final packets since remaining exceeds the lane count there.
    always_comb begin
        half   = (state_q == StEmitHi) ? line_q[PKT_WIDTH +: PKT_WIDTH] : line_q[0 +: PKT_WIDTH];
        packet = '0;
        for (int unsigned i = 0; i < NUM_OF_BANKS; i++) begin
            if (lane_live(i, remaining_q)) begin
                packet[i*B_WIDTH +: B_WIDTH] = half[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            samples_q   <= '0;
            epochs_q    <= '0;
            epoch_cnt_q <= '0;
            remaining_q <= '0;
            line_q      <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            samples_q   <= samples_d;
            epochs_q    <= epochs_d;
            epoch_cnt_q <= epoch_cnt_d;
            remaining_q <= remaining_d;
            line_q      <= line_d;
            wr_en_q     <= emit;
            if (emit) begin
                data_q <= packet;
            end
        end
    end

    assign bus.mem_b_ready          = mem_ready;
    assign bus.dispatch_axb_b_data  = data_q;
    assign bus.dispatch_axb_b_wr_en = wr_en_q;

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign epoch_cnt = epoch_cnt_q;

endmodule

// File: tb/tb_sgd_b_dispatch.sv
// Self-checking bench for sgd_b_dispatch: directed jobs plus randomized valid/backpressure jobs,
// each compared against a sample-index model of the expected packet stream.
module tb_sgd_b_dispatch;
    import sgd_b_dispatch_pkg::*;

    localparam int unsigned PW = B_WIDTH * NUM_OF_BANKS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] samples = '0;
    logic [15:0] epochs = '0;
    logic        busy;
    logic        done;
    logic [15:0] epoch_cnt;

    sgd_b_dispatch_if bus ();

    sgd_b_dispatch #(
        .NUM_OF_BANKS(NUM_OF_BANKS),
        .LINE_WIDTH  (LINE_WIDTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .number_of_samples(samples),
        .number_of_epochs (epochs),
        .bus              (bus),
        .busy             (busy),
        .done             (done),
        .epoch_cnt        (epoch_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [LINE_WIDTH-1:0] cur_line;
    logic [LINE_WIDTH-1:0] consumed[$];
    logic [PW-1:0]         got[$];
    int                    wr_cyc[$];
    int                    cyc, done_cnt, done_cyc, af_viol, hold_viol, stall_left;
    logic [15:0]           done_epoch;
    logic [PW-1:0]         last_data;
    bit                    check_hold;
    bit                    rand_valid;
    int                    af_mode;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_WIDTH-1:0] rand_line();
        logic [LINE_WIDTH-1:0] l;
        for (int j = 0; j < LINE_WIDTH / B_WIDTH; j++) l[j*B_WIDTH +: B_WIDTH] = $urandom;
        return l;
    endfunction

    // One clock: records handshakes, writes and done, then drives the next memory/backpressure inputs.
    task automatic tick();
        logic hs, af_e;
        hs   = bus.mem_b_valid & bus.mem_b_ready;
        af_e = bus.dispatch_axb_b_almost_full;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            consumed.push_back(cur_line);
            cur_line = rand_line();
        end
        bus.mem_b_data = cur_line;
        if (bus.dispatch_axb_b_wr_en) begin
            got.push_back(bus.dispatch_axb_b_data);
            wr_cyc.push_back(cyc);
            if (af_e) af_viol++;
        end else if (check_hold && bus.dispatch_axb_b_data !== last_data) begin
            hold_viol++;
        end
        last_data = bus.dispatch_axb_b_data;
        if (done) begin
            done_cnt++;
            done_cyc   = cyc;
            done_epoch = epoch_cnt;
        end
        bus.mem_b_valid = rand_valid ? ($urandom_range(0, 9) < 7) : 1'b1;
        case (af_mode)
            1: bus.dispatch_axb_b_almost_full = ($urandom_range(0, 3) == 0);
            2: begin
                if (got.size() == 1 && stall_left > 0) begin
                    bus.dispatch_axb_b_almost_full = 1'b1;
                    stall_left--;
                end else begin
                    bus.dispatch_axb_b_almost_full = 1'b0;
                end
            end
            default: bus.dispatch_axb_b_almost_full = 1'b0;
        endcase
    endtask

    task automatic clear_obs();
        got.delete();
        consumed.delete();
        wr_cyc.delete();
        done_cnt   = 0;
        done_cyc   = 0;
        done_epoch = '0;
        af_viol    = 0;
        hold_viol  = 0;
        cyc        = 1;  // the cycle in which start is driven counts as cycle 1
    endtask

    // Runs one job and compares the packet stream with the sample-index model.
    task automatic run_job(input int s, input int e, input string tag);
        int ppe, lpe, n_exp, li, k;
        logic [LINE_WIDTH-1:0] line;
        logic [PW-1:0] exp_pkt;
        clear_obs();
        samples = 32'(s);
        epochs  = 16'(e);
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 3000 && done_cnt == 0; n++) tick();
        chk({tag, "_done_seen"}, PW'(done_cnt), PW'(1));
        tick();
        chk({tag, "_busy_cleared"}, PW'(busy), PW'(0));
        tick();
        tick();
        chk({tag, "_single_done"}, PW'(done_cnt), PW'(1));

        ppe   = (s + 7) / 8;
        lpe   = (s + 15) / 16;
        n_exp = (s == 0 || e == 0) ? 0 : e * ppe;
        chk({tag, "_writes"}, PW'(got.size()), PW'(n_exp));
        chk({tag, "_lines"}, PW'(consumed.size()), PW'((s == 0 || e == 0) ? 0 : e * lpe));
        chk({tag, "_epoch_cnt"}, PW'(done_epoch), PW'((s == 0 || e == 0) ? 0 : e));
        chk({tag, "_no_wr_under_af"}, PW'(af_viol), PW'(0));
        chk({tag, "_data_held"}, PW'(hold_viol), PW'(0));
        for (int p = 0; p < n_exp && p < got.size(); p++) begin
            k  = p % ppe;
            li = (p / ppe) * lpe + k / 2;
            line = (li < consumed.size()) ? consumed[li] : '0;
            for (int i = 0; i < 8; i++) begin
                exp_pkt[i*32 +: 32] = (k * 8 + i < s) ? line[((k % 2) * 8 + i) * 32 +: 32] : 32'd0;
            end
            chk($sformatf("%s_pkt%0d", tag, p), got[p], exp_pkt);
        end
    endtask

    initial begin
        bus.mem_b_valid = 1'b0;
        bus.dispatch_axb_b_almost_full = 1'b0;
        cur_line = rand_line();
        bus.mem_b_data = cur_line;
        rand_valid = 1'b0;
        af_mode    = 0;
        check_hold = 1'b0;
        stall_left = 0;
        clear_obs();

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", PW'(busy), PW'(0));
        chk("rst_done", PW'(done), PW'(0));
        chk("rst_ready", PW'(bus.mem_b_ready), PW'(0));
        chk("rst_wr_en", PW'(bus.dispatch_axb_b_wr_en), PW'(0));
        chk("rst_epoch_cnt", PW'(epoch_cnt), PW'(0));
        chk("rst_data", bus.dispatch_axb_b_data, PW'(0));
        check_hold = 1'b1;

        run_job(16, 1, "s16e1");
        run_job(13, 2, "s13e2");
        run_job(8, 3, "s8e3");

        // Backpressure for 10 cycles right after the first write.
        af_mode    = 2;
        stall_left = 10;
        run_job(32, 1, "stall");
        chk("stall_gap", PW'(wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : 0), PW'(11));
        af_mode = 0;

        // Unstalled: writes land in cycles 4,5,7,8 (two packets every three cycles).
        run_job(32, 1, "tput");
        chk("tput_first", PW'(wr_cyc.size() > 0 ? wr_cyc[0] : 0), PW'(4));
        chk("tput_last", PW'(wr_cyc.size() > 3 ? wr_cyc[3] : 0), PW'(8));

        // Empty jobs: done in cycle 2 counting the start cycle as cycle 1.
        run_job(0, 5, "s0e5");
        chk("s0e5_done_cycle", PW'(done_cyc), PW'(2));
        run_job(5, 0, "s5e0");
        chk("s5e0_done_cycle", PW'(done_cyc), PW'(2));

        // Reset between the 2nd and 3rd write of a long job.
        clear_obs();
        samples = 32'd64;
        epochs  = 16'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 200 && got.size() < 2; n++) tick();
        chk("rst_mid_two_writes", PW'(got.size()), PW'(2));
        check_hold = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_busy", PW'(busy), PW'(0));
        chk("rst_mid_wr_en", PW'(bus.dispatch_axb_b_wr_en), PW'(0));
        chk("rst_mid_data", bus.dispatch_axb_b_data, PW'(0));
        chk("rst_mid_epoch", PW'(epoch_cnt), PW'(0));
        check_hold = 1'b1;
        repeat (20) tick();
        chk("rst_mid_no_more_writes", PW'(got.size()), PW'(2));
        chk("rst_mid_no_done", PW'(done_cnt), PW'(0));
        chk("rst_mid_idle", PW'(busy), PW'(0));
        run_job(16, 1, "after_rst");

        // Randomized lengths, memory valid gaps and backpressure.
        rand_valid = 1'b1;
        af_mode    = 1;
        for (int r = 0; r < 8; r++) begin
            run_job($urandom_range(1, 70), $urandom_range(1, 3), $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
